array_memory_engine: RTL and testbench
======================================

Name: array_memory_engine

Overview:
- Parametrised heap of fixed-block arrays: ARRAYS arrays, each holding up to ARRAY_LENGTH elements of DATA_BITS, with a per-array current size.
- Executes one action at a time under a start/busy/done handshake; element-scanning actions (count greater, count less, find) take one element per clock.
- Sits between a test program sequencer and storage, as the program's array memory.

Parameters:
- ADDRESS_BITS, 8, bits selecting an array; ARRAYS = 2**ADDRESS_BITS.
- INDEX_BITS, 3, bits of element index; ARRAY_LENGTH = 2**INDEX_BITS.
- DATA_BITS, 16, element width; must exceed INDEX_BITS so counts and indices fit in out.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only when busy=0.
- action  input  8  operation code, sampled at accept.
- array  input  ADDRESS_BITS  target array, sampled at accept.
- index  input  INDEX_BITS  element index, sampled at accept.
- in  input  DATA_BITS  operand, sampled at accept.
- busy  output  1  high from the cycle after accept until the done cycle, inclusive.
- done  output  1  one-cycle pulse; out and error valid in this cycle and held until the next accept.
- out  output  DATA_BITS  result.
- error  output  32  0 = ok, else error code.

Behaviour:
- Reset values: busy=0, done=0, out=0, error=0, every arraySize=0, state IDLE. Element storage is not cleared.
- States:
  - IDLE: start=1 captures the inputs and goes to EXEC.
  - EXEC: single-cycle actions, and scans with size 0, go to DONE; scans with size>0 go to SCAN.
  - SCAN: i runs 0..size-1, one element per cycle, then goes to DONE.
  - DONE: done=1, then returns to IDLE.
- Action codes:
  - 1 Clear: size:=0; out=0.
  - 2 Write: index<size required; mem[index]:=in; out=in.
  - 3 Read: index<size required; out=mem[index].
  - 4 Size: out=size (zero-extended).
  - 5 Push: size<ARRAY_LENGTH required; mem[size]:=in; size:=size+1; out=new size.
  - 6 Pop: size>0 required; size:=size-1; out=popped element.
  - 9 Greater: out = count of elements, over i<size, with mem[i] > in.
  - 10 Less: out = count of elements, over i<size, with mem[i] < in.
  - 11 Find: out = lowest i with mem[i]==in; the scan terminates at the first match.
- Latency from the accept edge T: single-cycle actions assert done at T+2. Greater/Less assert done at T+2+size. Find asserts done at T+2+(matchIndex+1), or T+2+size if there is no match.
- Error codes (on error, no state changes and out=0):
  - 1: index>=size on Write/Read.
  - 2: Push when full.
  - 3: Pop when empty.
  - 4: Find with no match.
  - 5: unknown action.
- Comparisons are unsigned by default. Counts saturate only at ARRAY_LENGTH, which always fits.
- start while busy=1 is ignored; no queueing. start in the DONE cycle is also ignored.
- reset asserted mid-scan aborts the action, with no done pulse. All sizes clear at the same edge.
- size is INDEX_BITS+1 wide. A full array has size ARRAY_LENGTH, and Push must not wrap size.
- Arrays are independent; an action touches only the selected array.

Optional Feature:
- Macro ARRAY_MEMORY_SIGNED_EN.
- When defined: Greater, Less and Find compare mem[i] and in as two's-complement signed DATA_BITS values.
- When undefined: all comparisons are unsigned.
- Storage, sizes, errors and timing are identical in both builds.

Test Plan:
- Params 2/3/12. Reset, then Size on array 2 -> out=0, error=0, done at T+2.
- Push 5,9,3,7 to array 1 -> out=1,2,3,4. Size -> 4. Read index 2 -> 3. Read index 4 -> error=1, out=0.
- Array 1 = {5,9,3,7}: Greater in=4 -> out=3, done at T+6. Less in=7 -> out=2. Find in=3 -> out=2, done at T+5. Find in=8 -> error=4.
- Push 8 elements to array 0, ninth Push -> error=2, size stays 8. Pop x8 returns elements in reverse order; ninth Pop -> error=3.
- Start during busy is ignored, and out is unchanged. Reset during a Greater scan -> no done, busy=0 next cycle, all sizes 0.
- Signed build: array 3 = {0xFFF, 0x001}, Greater in=0 -> out=1. Unsigned build gives the same case -> out=2.

Source files
------------

// File: rtl/array_memory_engine.sv
// Heap of fixed-block arrays with per-array size, one action at a time.
// Define ARRAY_MEMORY_SIGNED_EN for signed Greater/Less/Find comparisons.
module array_memory_engine #(
    parameter int ADDRESS_BITS = 8,
    parameter int INDEX_BITS   = 3,
    parameter int DATA_BITS    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              action,
    input  logic [ADDRESS_BITS-1:0] array,
    input  logic [INDEX_BITS-1:0]   index,
    input  logic [DATA_BITS-1:0]    in,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_BITS-1:0]    out,
    output logic [31:0]             error
);

    localparam int ARRAYS       = 2 ** ADDRESS_BITS;
    localparam int ARRAY_LENGTH = 2 ** INDEX_BITS;
    localparam int SB           = INDEX_BITS + 1;
    localparam int AW           = ADDRESS_BITS + INDEX_BITS;

    localparam logic [7:0] A_CLEAR = 8'd1;
    localparam logic [7:0] A_WRITE = 8'd2;
    localparam logic [7:0] A_READ  = 8'd3;
    localparam logic [7:0] A_SIZE  = 8'd4;
    localparam logic [7:0] A_PUSH  = 8'd5;
    localparam logic [7:0] A_POP   = 8'd6;
    localparam logic [7:0] A_GT    = 8'd9;
    localparam logic [7:0] A_LT    = 8'd10;
    localparam logic [7:0] A_FIND  = 8'd11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SCAN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [7:0]              act_q;
    logic [ADDRESS_BITS-1:0] arr_q;
    logic [INDEX_BITS-1:0]   idx_q;
    logic [DATA_BITS-1:0]    in_q;

    logic [DATA_BITS-1:0] mem   [ARRAYS*ARRAY_LENGTH];
    logic [SB-1:0]        sizes [ARRAYS];

    logic [INDEX_BITS-1:0] scan_i;
    logic [SB-1:0]         cnt;
    logic [DATA_BITS-1:0]  out_q;
    logic [31:0]           err_q;

    logic [SB-1:0]         cur_size;
    logic [INDEX_BITS-1:0] top_i;
    logic [DATA_BITS-1:0]  elem;
    logic                  idx_ok;
    logic                  full;
    logic                  empty;
    logic                  last;
    logic                  hit;

    logic                 mem_we;
    logic [AW-1:0]        mem_wa;
    logic [DATA_BITS-1:0] mem_wd;
    logic                 size_we;
    logic [SB-1:0]        size_wd;
    logic                 res_we;
    logic [DATA_BITS-1:0] res_out;
    logic [31:0]          res_err;

    function automatic logic gt(input logic [DATA_BITS-1:0] a,
                                input logic [DATA_BITS-1:0] b);
`ifdef ARRAY_MEMORY_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    assign cur_size = sizes[arr_q];
    assign full     = cur_size[INDEX_BITS];
    assign empty    = (cur_size == '0);
    assign idx_ok   = ({1'b0, idx_q} < cur_size);
    assign top_i    = cur_size[INDEX_BITS-1:0] - INDEX_BITS'(1);
    assign elem     = mem[{arr_q, scan_i}];
    assign last     = ({1'b0, scan_i} == cur_size - SB'(1));

    always_comb begin
        hit = 1'b0;
        case (act_q)
            A_GT:    hit = gt(elem, in_q);
            A_LT:    hit = gt(in_q, elem);
            A_FIND:  hit = (elem == in_q);
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        mem_we  = 1'b0;
        mem_wa  = {arr_q, idx_q};
        mem_wd  = in_q;
        size_we = 1'b0;
        size_wd = cur_size;
        res_we  = 1'b0;
        res_out = '0;
        res_err = '0;
        unique case (state)
            IDLE: begin
                if (start) state_n = EXEC;
            end
            EXEC: begin
                state_n = DONE;
                res_we  = 1'b1;
                case (act_q)
                    A_CLEAR: begin
                        size_we = 1'b1;
                        size_wd = '0;
                    end
                    A_WRITE: begin
                        if (idx_ok) begin
                            mem_we  = 1'b1;
                            res_out = in_q;
                        end else begin
                            res_err = 32'd1;
                        end
                    end
                    A_READ: begin
                        if (idx_ok) res_out = mem[{arr_q, idx_q}];
                        else        res_err = 32'd1;
                    end
                    A_SIZE: res_out = DATA_BITS'(cur_size);
                    A_PUSH: begin
                        if (!full) begin
                            mem_we  = 1'b1;
                            mem_wa  = {arr_q, cur_size[INDEX_BITS-1:0]};
                            size_we = 1'b1;
                            size_wd = cur_size + SB'(1);
                            res_out = DATA_BITS'(cur_size + SB'(1));
                        end else begin
                            res_err = 32'd2;
                        end
                    end
                    A_POP: begin
                        if (!empty) begin
                            size_we = 1'b1;
                            size_wd = cur_size - SB'(1);
                            res_out = mem[{arr_q, top_i}];
                        end else begin
                            res_err = 32'd3;
                        end
                    end
                    A_GT, A_LT: begin
                        if (!empty) begin
                            res_we  = 1'b0;
                            state_n = SCAN;
                        end
                    end
                    A_FIND: begin
                        if (!empty) begin
                            res_we  = 1'b0;
                            state_n = SCAN;
                        end else begin
                            res_err = 32'd4;
                        end
                    end
                    default: res_err = 32'd5;
                endcase
            end
            SCAN: begin
                if (act_q == A_FIND && hit) begin
                    res_we  = 1'b1;
                    res_out = DATA_BITS'(scan_i);
                    state_n = DONE;
                end else if (last) begin
                    res_we  = 1'b1;
                    state_n = DONE;
                    if (act_q == A_FIND) res_err = 32'd4;
                    else res_out = DATA_BITS'(cnt + SB'(hit));
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            out_q  <= '0;
            err_q  <= '0;
            scan_i <= '0;
            cnt    <= '0;
            act_q  <= '0;
            arr_q  <= '0;
            idx_q  <= '0;
            in_q   <= '0;
            for (int k = 0; k < ARRAYS; k++) sizes[k] <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                act_q <= action;
                arr_q <= array;
                idx_q <= index;
                in_q  <= in;
            end
            if (state == EXEC) begin
                scan_i <= '0;
                cnt    <= '0;
            end else if (state == SCAN) begin
                scan_i <= scan_i + INDEX_BITS'(1);
                cnt    <= cnt + SB'(hit);
            end
            if (size_we) sizes[arr_q] <= size_wd;
            if (res_we) begin
                out_q <= res_out;
                err_q <= res_err;
            end
        end
    end

    // Element storage keeps its contents across reset.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) mem[mem_wa] <= mem_wd;
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign out   = out_q;
    assign error = err_q;

endmodule

// File: tb/tb_array_memory_engine.sv
// Bench for array_memory_engine: fixed vectors, corner sequences and
// random actions checked against a queue-based reference model.
module tb_array_memory_engine;

    localparam int AB = 2;
    localparam int IB = 3;
    localparam int DB = 12;
    localparam int NA = 4;
    localparam int LEN = 8;

`ifdef ARRAY_MEMORY_SIGNED_EN
    localparam int SGN_EXP = 1;
`else
    localparam int SGN_EXP = 2;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    action;
    logic [AB-1:0] array;
    logic [IB-1:0] index;
    logic [DB-1:0] in;
    logic          busy;
    logic          done;
    logic [DB-1:0] out;
    logic [31:0]   error;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DB-1:0] q [NA][$];

    array_memory_engine #(
        .ADDRESS_BITS(AB),
        .INDEX_BITS  (IB),
        .DATA_BITS   (DB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .action(action),
        .array (array),
        .index (index),
        .in    (in),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .error (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  act;
        int          arr;
        int          idx;
        int          din;
        int          eo;
        int          ee;
        int          el;
    } vec_t;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit mgt(input logic [DB-1:0] a,
                               input logic [DB-1:0] b);
`ifdef ARRAY_MEMORY_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    task automatic model(input logic [7:0] a, input int ar, input int ix,
                         input logic [DB-1:0] d, output int o,
                         output int e, output int lat);
        int sz;
        sz  = q[ar].size();
        o   = 0;
        e   = 0;
        lat = 2;
        case (a)
            8'd1: q[ar].delete();
            8'd2: if (ix < sz) begin q[ar][ix] = d; o = d; end else e = 1;
            8'd3: if (ix < sz) o = q[ar][ix]; else e = 1;
            8'd4: o = sz;
            8'd5: if (sz < LEN) begin q[ar].push_back(d); o = sz + 1; end
                  else e = 2;
            8'd6: if (sz > 0) o = q[ar].pop_back(); else e = 3;
            8'd9, 8'd10: begin
                for (int i = 0; i < sz; i++)
                    if (a == 8'd9 ? mgt(q[ar][i], d) : mgt(d, q[ar][i]))
                        o++;
                lat = 2 + sz;
            end
            8'd11: begin
                e = 4;
                lat = 2 + sz;
                for (int i = 0; i < sz; i++)
                    if (e == 4 && q[ar][i] == d) begin
                        e = 0; o = i; lat = 3 + i;
                    end
            end
            default: e = 5;
        endcase
    endtask

    task automatic op(input logic [7:0] a, input int ar, input int ix,
                      input int d, output int o, output int e,
                      output int lat);
        @(negedge clock);
        action = a;
        array  = AB'(ar);
        index  = IB'(ix);
        in     = DB'(d);
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        o = int'(out);
        e = int'(error);
    endtask

    task automatic run(input string nm, input logic [7:0] a, input int ar,
                       input int ix, input int d);
        int o, e, l, mo, me, ml;
        op(a, ar, ix, d, o, e, l);
        model(a, ar, ix, DB'(d), mo, me, ml);
        check({nm, ".out"}, o, mo);
        check({nm, ".err"}, e, me);
        check({nm, ".lat"}, l, ml);
    endtask

    vec_t tbl [$];

    initial begin
        int o, e, l, mo, me, ml, acts [10];
        reset = 1'b1; start = 1'b0; action = '0;
        array = '0; index = '0; in = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.out", out, 0);
        check("rst.err", error, 0);

        tbl = '{
            '{8'd4, 2, 0, 0, 0, 0, 2},
            '{8'd5, 1, 0, 5, 1, 0, 2},
            '{8'd5, 1, 0, 9, 2, 0, 2},
            '{8'd5, 1, 0, 3, 3, 0, 2},
            '{8'd5, 1, 0, 7, 4, 0, 2},
            '{8'd4, 1, 0, 0, 4, 0, 2},
            '{8'd3, 1, 2, 0, 3, 0, 2},
            '{8'd3, 1, 4, 0, 0, 1, 2},
            '{8'd9, 1, 0, 4, 3, 0, 6},
            '{8'd10, 1, 0, 7, 2, 0, 6},
            '{8'd11, 1, 0, 3, 2, 0, 5},
            '{8'd11, 1, 0, 8, 0, 4, 6},
            '{8'd2, 1, 0, 12, 12, 0, 2},
            '{8'd3, 1, 0, 0, 12, 0, 2},
            '{8'd7, 1, 0, 0, 0, 5, 2},
            '{8'd1, 1, 0, 0, 0, 0, 2},
            '{8'd4, 1, 0, 0, 0, 0, 2},
            '{8'd9, 1, 0, 0, 0, 0, 2},
            '{8'd11, 1, 0, 0, 0, 4, 2},
            '{8'd6, 1, 0, 0, 0, 3, 2},
            '{8'd5, 3, 0, 'hFFF, 1, 0, 2},
            '{8'd5, 3, 0, 'h001, 2, 0, 2},
            '{8'd9, 3, 0, 0, SGN_EXP, 0, 4}
        };
        foreach (tbl[k]) begin
            op(tbl[k].act, tbl[k].arr, tbl[k].idx, tbl[k].din, o, e, l);
            model(tbl[k].act, tbl[k].arr, tbl[k].idx, DB'(tbl[k].din),
                  mo, me, ml);
            check($sformatf("tbl%0d.out", k), o, tbl[k].eo);
            check($sformatf("tbl%0d.err", k), e, tbl[k].ee);
            check($sformatf("tbl%0d.lat", k), l, tbl[k].el);
        end

        for (int i = 0; i < 9; i++)
            run($sformatf("push%0d", i), 8'd5, 0, 0, 100 + i);
        run("size_full", 8'd4, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            run($sformatf("pop%0d", i), 8'd6, 0, 0, 0);

        for (int i = 0; i < 4; i++) run("fill2", 8'd5, 2, 0, 10 * i);
        @(negedge clock);
        action = 8'd9; array = 2'd2; in = 12'd15; start = 1'b1;
        @(negedge clock);
        action = 8'd1; l = 1;
        while (!done && l < 100) begin
            @(negedge clock);
            l++;
        end
        check("busy_ign.out", out, 2);
        check("busy_ign.lat", l, 6);
        @(negedge clock);
        start = 1'b0;
        check("done_ign.busy", busy, 0);
        run("busy_ign.size", 8'd4, 2, 0, 0);

        @(negedge clock);
        action = 8'd9; array = 2'd2; in = 12'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstscan.busy", busy, 0);
        check("rstscan.done", done, 0);
        check("rstscan.out", out, 0);
        for (int k = 0; k < NA; k++) q[k].delete();
        o = 0;
        repeat (6) begin
            @(negedge clock);
            if (done) o++;
        end
        check("rstscan.nodone", o, 0);
        for (int k = 0; k < NA; k++)
            run($sformatf("rstscan.size%0d", k), 8'd4, k, 0, 0);

        acts = '{1, 2, 3, 4, 5, 6, 9, 10, 11, 0};
        for (int n = 0; n < 250; n++) begin
            int sel, d;
            logic [7:0] a;
            sel = int'($urandom_range(0, 13));
            a = sel > 9 ? 8'd5 : 8'(acts[sel]);
            if (sel == 9) a = 8'($urandom_range(12, 255));
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                            : int'($urandom_range(0, 7));
            run($sformatf("rnd%0d", n), a, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 7)), d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
